// File: rtl/sme_pattern_compiler.sv
// Compiles a pattern byte burst into a fixed-slot match descriptor. The descriptor
// is valid one cycle after the burst ends and is held in HOLD until out_ready.
module sme_pattern_compiler #(
   parameter int MAX_LEN = 8,
   parameter int CW      = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CW-1:0]         chardata,
   input  logic                  ispattern,
   input  logic                  out_ready,
   output logic                  out_valid,
   output logic                  busy,
   output logic [MAX_LEN*CW-1:0] pat_chars,
   output logic [MAX_LEN-1:0]    wild_mask,
   output logic [3:0]            pat_len,
   output logic                  anchor_head,
   output logic                  anchor_tail,
   output logic                  star_en,
   output logic [2:0]            star_pos,
   output logic                  err_overflow
);

   localparam int IW = $clog2(MAX_LEN);
   localparam logic [CW-1:0] CH_CARET  = CW'(8'h5E);
   localparam logic [CW-1:0] CH_DOT    = CW'(8'h2E);
   localparam logic [CW-1:0] CH_STAR   = CW'(8'h2A);
   localparam logic [CW-1:0] CH_DOLLAR = CW'(8'h24);
   localparam logic [3:0]    LEN_MAX   = 4'(MAX_LEN);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   state_t state_q, state_n;

   logic [MAX_LEN-1:0][CW-1:0] chars_q, chars_n;
   logic [MAX_LEN-1:0]         wild_q, wild_n;
   logic [3:0]                 len_q, len_n;
   logic                       head_q, head_n;
   logic                       tail_q, tail_n;
   logic                       star_q, star_n;
   logic [2:0]                 spos_q, spos_n;
   logic                       ovf_q, ovf_n;
   logic                       last_dollar_q, last_dollar_n;
   // '$' seen with all slots full: it still anchors, but must not shrink pat_len
   logic                       dollar_drop_q, dollar_drop_n;
   logic                       take;
   logic                       first;
   logic [3:0]                 len_m1;

   assign len_m1 = len_q - 4'd1;

   always_comb begin
      state_n       = state_q;
      chars_n       = chars_q;
      wild_n        = wild_q;
      len_n         = len_q;
      head_n        = head_q;
      tail_n        = tail_q;
      star_n        = star_q;
      spos_n        = spos_q;
      ovf_n         = ovf_q;
      last_dollar_n = last_dollar_q;
      dollar_drop_n = dollar_drop_q;
      take          = 1'b0;
      first         = 1'b0;

      case (state_q)
         IDLE: begin
            if (ispattern) begin
               state_n       = LOAD;
               take          = 1'b1;
               first         = 1'b1;
               chars_n       = '0;
               wild_n        = '0;
               len_n         = '0;
               head_n        = 1'b0;
               tail_n        = 1'b0;
               star_n        = 1'b0;
               spos_n        = '0;
               ovf_n         = 1'b0;
               last_dollar_n = 1'b0;
               dollar_drop_n = 1'b0;
            end
         end
         LOAD: begin
            if (ispattern) begin
               take = 1'b1;
            end else begin
               state_n = HOLD;
               if (last_dollar_q) begin
                  tail_n = 1'b1;
                  if (!dollar_drop_q) begin
                     chars_n[len_m1[IW-1:0]] = '0;
                     len_n                   = len_m1;
                  end
               end
               last_dollar_n = 1'b0;
               dollar_drop_n = 1'b0;
            end
         end
         HOLD: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      if (take) begin
         // a dropped '$' turns out to be a literal once anything follows it
         if (last_dollar_n && dollar_drop_n) ovf_n = 1'b1;
         last_dollar_n = 1'b0;
         dollar_drop_n = 1'b0;
         if (first && chardata == CH_CARET) begin
            head_n = 1'b1;
         end else if (chardata == CH_STAR && !star_n) begin
            star_n = 1'b1;
            spos_n = len_n[2:0];
         end else if (len_n == LEN_MAX) begin
            if (chardata == CH_DOLLAR) begin
               last_dollar_n = 1'b1;
               dollar_drop_n = 1'b1;
            end else begin
               ovf_n = 1'b1;
            end
         end else begin
            chars_n[len_n[IW-1:0]] = chardata;
            if (chardata == CH_DOT)    wild_n[len_n[IW-1:0]] = 1'b1;
            if (chardata == CH_DOLLAR) last_dollar_n = 1'b1;
            len_n = len_n + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         chars_q       <= '0;
         wild_q        <= '0;
         len_q         <= '0;
         head_q        <= 1'b0;
         tail_q        <= 1'b0;
         star_q        <= 1'b0;
         spos_q        <= '0;
         ovf_q         <= 1'b0;
         last_dollar_q <= 1'b0;
         dollar_drop_q <= 1'b0;
      end else begin
         state_q       <= state_n;
         chars_q       <= chars_n;
         wild_q        <= wild_n;
         len_q         <= len_n;
         head_q        <= head_n;
         tail_q        <= tail_n;
         star_q        <= star_n;
         spos_q        <= spos_n;
         ovf_q         <= ovf_n;
         last_dollar_q <= last_dollar_n;
         dollar_drop_q <= dollar_drop_n;
      end
   end

   assign out_valid    = (state_q == HOLD);
   assign busy         = (state_q == HOLD);
   assign pat_chars    = chars_q;
   assign wild_mask    = wild_q;
   assign pat_len      = len_q;
   assign anchor_head  = head_q;
   assign anchor_tail  = tail_q;
   assign star_en      = star_q;
   assign star_pos     = spos_q;
   assign err_overflow = ovf_q;

endmodule

// File: tb/tb_sme_pattern_compiler.sv
// Directed bench for sme_pattern_compiler: hand-computed descriptors per pattern.
module tb_sme_pattern_compiler;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  chardata;
   logic        ispattern;
   logic        out_ready;
   logic        out_valid;
   logic        busy;
   logic [63:0] pat_chars;
   logic [7:0]  wild_mask;
   logic [3:0]  pat_len;
   logic        anchor_head;
   logic        anchor_tail;
   logic        star_en;
   logic [2:0]  star_pos;
   logic        err_overflow;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sme_pattern_compiler #(.MAX_LEN(8), .CW(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .chardata     (chardata),
      .ispattern    (ispattern),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .busy         (busy),
      .pat_chars    (pat_chars),
      .wild_mask    (wild_mask),
      .pat_len      (pat_len),
      .anchor_head  (anchor_head),
      .anchor_tail  (anchor_tail),
      .star_en      (star_en),
      .star_pos     (star_pos),
      .err_overflow (err_overflow)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(input string s);
      logic [63:0] v = '0;
      for (int i = 0; i < s.len() && i < 8; i++) v[8*i +: 8] = s[i];
      return v;
   endfunction

   // Drives one burst then one ispattern=0 cycle; next negedge is in HOLD.
   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) begin
         @(negedge clk);
         ispattern = 1'b1;
         chardata  = s[i];
      end
      @(negedge clk);
      ispattern = 1'b0;
      chardata  = 8'h00;
      @(negedge clk);
   endtask

   task automatic chk_desc(input string tag, input string slots, input logic [7:0] wm,
                           input int len, input bit h, input bit t, input bit se,
                           input int sp, input bit ov);
      check({tag, ".valid"}, 64'(out_valid),    64'd1);
      check({tag, ".busy"},  64'(busy),         64'd1);
      check({tag, ".chars"}, pat_chars,         pack(slots));
      check({tag, ".wild"},  64'(wild_mask),    64'(wm));
      check({tag, ".len"},   64'(pat_len),      64'(len));
      check({tag, ".head"},  64'(anchor_head),  64'(h));
      check({tag, ".tail"},  64'(anchor_tail),  64'(t));
      check({tag, ".star"},  64'(star_en),      64'(se));
      check({tag, ".spos"},  64'(star_pos),     64'(sp));
      check({tag, ".ovf"},   64'(err_overflow), 64'(ov));
   endtask

   task automatic pop(input string tag);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".pop_valid"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      reset     = 1'b0;
      chardata  = 8'h00;
      ispattern = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.busy",  64'(busy),      64'd0);
      check("rst.chars", pat_chars,      64'd0);
      check("rst.len",   64'(pat_len),   64'd0);
      check("rst.flags", 64'({anchor_head, anchor_tail, star_en, star_pos, err_overflow, wild_mask}), 64'd0);
      reset = 1'b1;

      send("^ab.d$");
      chk_desc("t1", "ab.d", 8'b0000_0100, 4, 1, 1, 0, 0, 0);
      pop("t1");
      check("t1.keep_len", 64'(pat_len), 64'd4);

      send("ab*cd");
      chk_desc("t2", "abcd", 8'h00, 4, 0, 0, 1, 2, 0);
      pop("t2");

      send("a$b");
      chk_desc("t3a", "a$b", 8'h00, 3, 0, 0, 0, 0, 0);
      pop("t3a");
      send("a^");
      chk_desc("t3b", "a^", 8'h00, 2, 0, 0, 0, 0, 0);
      pop("t3b");

      send("abcdefghij");
      chk_desc("t4a", "abcdefgh", 8'h00, 8, 0, 0, 0, 0, 1);
      pop("t4a");
      send("abcdefgh$");
      chk_desc("t4b", "abcdefgh", 8'h00, 8, 0, 1, 0, 0, 0);
      pop("t4b");

      send("a**");
      chk_desc("t7", "a*", 8'h00, 2, 0, 0, 1, 1, 0);
      pop("t7");
      send("^");
      chk_desc("t8a", "", 8'h00, 0, 1, 0, 0, 0, 0);
      pop("t8a");
      send("$");
      chk_desc("t8b", "", 8'h00, 0, 0, 1, 0, 0, 0);
      pop("t8b");

      send("mn");
      chk_desc("t5", "mn", 8'h00, 2, 0, 0, 0, 0, 0);
      for (int c = 0; c < 5; c++) begin
         ispattern = c[0] ? 1'b0 : 1'b1;
         chardata  = 8'h7A;
         @(negedge clk);
         check("t5.hold_valid", 64'(out_valid), 64'd1);
         check("t5.hold_chars", pat_chars,      pack("mn"));
         check("t5.hold_len",   64'(pat_len),   64'd2);
      end
      ispattern = 1'b0;
      chardata  = 8'h00;
      pop("t5");
      send("xy");
      chk_desc("t5n", "xy", 8'h00, 2, 0, 0, 0, 0, 0);
      pop("t5n");

      @(negedge clk);
      ispattern = 1'b1;
      chardata  = "a";
      @(negedge clk);
      chardata  = "b";
      @(negedge clk);
      ispattern = 1'b0;
      reset     = 1'b0;
      #1;
      check("t6.valid", 64'(out_valid), 64'd0);
      check("t6.chars", pat_chars,      64'd0);
      check("t6.len",   64'(pat_len),   64'd0);
      @(negedge clk);
      check("t6.still_idle", 64'(busy), 64'd0);
      reset = 1'b1;
      send("xy");
      chk_desc("t6n", "xy", 8'h00, 2, 0, 0, 0, 0, 0);
      pop("t6n");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
